// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register map and FSM encoding shared by the interrupt controller
package int_ctrl_pkg;
   localparam int ADDR_PEND   = 0;
   localparam int ADDR_MASK   = 1;
   localparam int ADDR_STATUS = 2;
   localparam int ADDR_EOI    = 3;
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
endpackage

// File: rtl/int_priority_ctrl_if.sv
// int_priority_ctrl_if: CPU I/O bus and interrupt handshake of the interrupt controller
interface int_priority_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32,
   parameter int VEC_W  = 4
);
   logic              IO_CS_;
   logic              IO_RD_;
   logic              IO_WR_;
   logic [ADDR_W-1:0] io_addr;
   logic [DATA_W-1:0] io_din;
   logic [DATA_W-1:0] io_dout;
   logic              interrupt;
   logic              int_ack;
   logic [VEC_W-1:0]  int_vector;
   logic              in_service;
   modport master (
      output IO_CS_, IO_RD_, IO_WR_, io_addr, io_din, int_ack,
      input  io_dout, interrupt, int_vector, in_service
   );
   modport slave (
      input  IO_CS_, IO_RD_, IO_WR_, io_addr, io_din, int_ack,
      output io_dout, interrupt, int_vector, in_service
   );
endinterface

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-first priority encoder
module int_prio_enc #(
   parameter int NUM_SRC = 8,
   parameter int VEC_W   = 4
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [VEC_W-1:0]   idx
);
   assign valid = |req;
   // scan downwards so the lowest set index is the last one written
   always_comb begin
      idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (req[i]) idx = VEC_W'(i);
   end
endmodule

// File: rtl/int_priority_ctrl.sv
// int_priority_ctrl: fixed-priority interrupt controller; INTC_SYNC_EN adds a 2-flop irq synchronizer
module int_priority_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   parameter int VEC_W   = 4
) (
   input logic                clk,
   input logic                reset,
   input logic [NUM_SRC-1:0]  irq_in,
   int_priority_ctrl_if.slave bus
);
   logic [NUM_SRC-1:0] irq_s, irq_q, rise, pend, mask, req, w1c, ack_clr;
   logic [VEC_W-1:0]   act_id, vec, low;
   logic               any, wr, rd, ack, eoi;
   state_t             state, state_nx;
`ifdef INTC_SYNC_EN
   logic [NUM_SRC-1:0] sync1, sync2;
   // two-flop synchronizer for asynchronous request lines
   always_ff @(posedge clk or negedge reset)
      if (!reset) {sync2, sync1} <= '0;
      else        {sync2, sync1} <= {sync1, irq_in};
   assign irq_s = sync2;
`else
   assign irq_s = irq_in;
`endif
   assign rise    = irq_s & ~irq_q;
   assign wr      = !bus.IO_CS_ && !bus.IO_WR_;
   assign rd      = !bus.IO_CS_ && !bus.IO_RD_;
   assign eoi     = wr && bus.io_addr == ADDR_W'(ADDR_EOI);
   assign ack     = state == REQ && bus.int_ack;
   assign w1c     = wr && bus.io_addr == ADDR_W'(ADDR_PEND) ? bus.io_din[NUM_SRC-1:0] : '0;
   assign ack_clr = ack ? NUM_SRC'(1) << act_id : '0;
   assign req     = pend & mask;
   int_prio_enc #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) u_enc (.req(req), .valid(any), .idx(low));
   // next state and handshake outputs; nesting is not supported so SERVICE only leaves on EOI
   always_comb begin
      state_nx = state == IDLE ? (any ? REQ : IDLE)
               : state == REQ  ? (bus.int_ack ? SERVICE : REQ)
               : (eoi ? IDLE : SERVICE);
      bus.interrupt  = state == REQ;
      bus.in_service = state == SERVICE;
      bus.int_vector = vec;
   end
   // state, request capture and register file; new edges win over any clear
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state  <= IDLE;
         act_id <= '0;
         vec    <= '0;
         irq_q  <= '0;
         pend   <= '0;
         mask   <= '0;
      end else begin
         state <= state_nx;
         irq_q <= irq_s;
         pend  <= (pend & ~w1c & ~ack_clr) | rise;
         if (state == IDLE && any) act_id <= low;
         if (ack) vec <= act_id;
         if (wr && bus.io_addr == ADDR_W'(ADDR_MASK)) mask <= bus.io_din[NUM_SRC-1:0];
      end
   // combinational read port; reflects pre-write state when RD and WR overlap
   always_comb begin
      bus.io_dout = !rd ? '0
                  : bus.io_addr == ADDR_W'(ADDR_PEND)   ? DATA_W'(pend)
                  : bus.io_addr == ADDR_W'(ADDR_MASK)   ? DATA_W'(mask)
                  : bus.io_addr == ADDR_W'(ADDR_STATUS) ? DATA_W'({bus.in_service, vec})
                  : '0;
   end
endmodule

// File: tb/tb_int_priority_ctrl.sv
// tb_int_priority_ctrl: scoreboard bench for int_priority_ctrl (honours INTC_SYNC_EN latency)
module tb_int_priority_ctrl;
   import int_ctrl_pkg::*;
   localparam int N = 8, AW = 4, DW = 32, VW = 4;
`ifdef INTC_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   logic          clk = 0;
   logic          reset = 1;
   logic [N-1:0]  irq_in = '0;
   int            n_chk = 0, n_fail = 0;
   logic [DW-1:0] rd_q[$];
   string         rd_name[$];
   logic [DW-1:0] mon_e;
   string         mon_n;
   logic [N-1:0]  m_pend, m_mask, v;
   int            e, k;

   int_priority_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .VEC_W(VW)) bus ();
   int_priority_ctrl #(.NUM_SRC(N), .ADDR_W(AW), .DATA_W(DW), .VEC_W(VW)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .bus(bus)
   );

   always #5 clk = ~clk;

   // monitor: every read strobe consumes one expected value from the scoreboard
   always @(negedge clk)
      if (reset && !bus.IO_CS_ && !bus.IO_RD_) begin
         n_chk++;
         if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: io_dout=%h with nothing expected", bus.io_dout);
         end else begin
            mon_e = rd_q.pop_front();
            mon_n = rd_name.pop_front();
            if (bus.io_dout !== mon_e) begin
               n_fail++;
               $display("FAIL %s: io_dout=%h expected=%h", mon_n, bus.io_dout, mon_e);
            end
         end
      end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d);
      bus.io_addr = AW'(a);
      bus.io_din  = d;
      bus.IO_CS_  = 0;
      bus.IO_WR_  = 0;
      tick(1);
      bus.IO_CS_  = 1;
      bus.IO_WR_  = 1;
   endtask

   task automatic rd(input int a, input logic [DW-1:0] exp, input string nm);
      rd_q.push_back(exp);
      rd_name.push_back(nm);
      bus.io_addr = AW'(a);
      bus.IO_CS_  = 0;
      bus.IO_RD_  = 0;
      tick(1);
      bus.IO_CS_  = 1;
      bus.IO_RD_  = 1;
   endtask

   task automatic ack();
      bus.int_ack = 1;
      tick(1);
      bus.int_ack = 0;
   endtask

   task automatic wait_int(input string nm);
      int c = 0;
      while (!bus.interrupt && c < 20) begin
         tick(1);
         c++;
      end
      chk(nm, DW'(bus.interrupt), 1);
   endtask

   task automatic pulse(input logic [N-1:0] p);
      irq_in = p;
      tick(1);
      irq_in = '0;
      tick(1 + LAT);
   endtask

   function automatic int lowest(input logic [N-1:0] p);
      for (int i = 0; i < N; i++)
         if (p[i]) return i;
      return -1;
   endfunction

   initial begin
      bus.IO_CS_ = 1; bus.IO_RD_ = 1; bus.IO_WR_ = 1;
      bus.io_addr = '0; bus.io_din = '0; bus.int_ack = 0;
      #2 reset = 0;
      #1;
      chk("rst_interrupt", DW'(bus.interrupt), 0);
      chk("rst_in_service", DW'(bus.in_service), 0);
      chk("rst_vector", DW'(bus.int_vector), 0);
      tick(2);
      reset = 1;
      tick(1);
      rd(ADDR_MASK, 0, "rst_mask");
      rd(ADDR_PEND, 0, "rst_pend");
      rd(ADDR_STATUS, 0, "rst_status");
      // masked request stays pending, enabling it raises the line
      pulse(8'h08);
      tick(1);
      chk("masked_no_int", DW'(bus.interrupt), 0);
      rd(ADDR_PEND, 32'h08, "pend_masked");
      wr(ADDR_MASK, 32'h08);
      chk("mask_edge_int0", DW'(bus.interrupt), 0);
      tick(1);
      chk("mask_then_int1", DW'(bus.interrupt), 1);
      ack();
      chk("ack3_int0", DW'(bus.interrupt), 0);
      chk("ack3_insvc", DW'(bus.in_service), 1);
      chk("ack3_vec", DW'(bus.int_vector), 3);
      rd(ADDR_STATUS, 32'h13, "status3");
      wr(ADDR_EOI, 0);
      chk("eoi3_insvc", DW'(bus.in_service), 0);
      // simultaneous edges: lowest index first, then back-to-back
      wr(ADDR_MASK, 32'hFF);
      pulse(8'h24);
      wait_int("int_2_5");
      ack();
      chk("vec2", DW'(bus.int_vector), 2);
      chk("insvc2", DW'(bus.in_service), 1);
      rd(ADDR_PEND, 32'h20, "pend_after2");
      wr(ADDR_EOI, 0);
      chk("eoi_idle_gap", DW'(bus.interrupt), 0);
      tick(1);
      chk("b2b_int", DW'(bus.interrupt), 1);
      ack();
      chk("vec5", DW'(bus.int_vector), 5);
      wr(ADDR_EOI, 0);
      // request persists without ack and survives a mask write
      pulse(8'h40);
      wait_int("int6");
      tick(10);
      chk("hold_int", DW'(bus.interrupt), 1);
      wr(ADDR_MASK, 0);
      chk("mask_no_cancel", DW'(bus.interrupt), 1);
      ack();
      chk("ack6_int0", DW'(bus.interrupt), 0);
      chk("vec6", DW'(bus.int_vector), 6);
      // asynchronous reset in SERVICE
      reset = 0;
      #1;
      chk("rst_svc_int", DW'(bus.interrupt), 0);
      chk("rst_svc_insvc", DW'(bus.in_service), 0);
      chk("rst_svc_vec", DW'(bus.int_vector), 0);
      reset = 1;
      tick(1);
      rd(ADDR_MASK, 0, "rst_svc_mask");
      // set beats W1C
      pulse(8'h04);
      irq_in = 8'h04;
      tick(LAT);
      wr(ADDR_PEND, 32'h04);
      irq_in = '0;
      rd(ADDR_PEND, 32'h04, "set_beats_w1c");
      tick(LAT);
      wr(ADDR_PEND, 32'h04);
      rd(ADDR_PEND, 0, "w1c");
      // overlapping read/write returns old value
      bus.io_addr = AW'(ADDR_MASK); bus.io_din = 32'h55;
      rd_q.push_back(0); rd_name.push_back("rdwr_old");
      bus.IO_CS_ = 0; bus.IO_RD_ = 0; bus.IO_WR_ = 0;
      tick(1);
      bus.IO_CS_ = 1; bus.IO_RD_ = 1; bus.IO_WR_ = 1;
      wr(5, 32'hFF);
      rd(ADDR_MASK, 32'h55, "rdwr_new");
      rd(7, 0, "unmapped");
      chk("dout_idle", bus.io_dout, 0);
      // edge-to-interrupt latency
      wr(ADDR_MASK, 32'h01);
      irq_in = 8'h01;
      k = 0;
      do begin
         tick(1);
         k++;
         irq_in = '0;
      end while (!bus.interrupt && k < 10);
      chk("latency", DW'(k), DW'(2 + LAT));
      ack();
      wr(ADDR_EOI, 0);
      // randomized rounds against the reference model
      for (int r = 0; r < 8; r++) begin
         wr(ADDR_MASK, 0);
         wr(ADDR_PEND, 32'hFF);
         m_pend = '0;
         for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
            v = N'($urandom);
            pulse(v);
            m_pend |= v;
         end
         rd(ADDR_PEND, DW'(m_pend), "rnd_pend");
         m_mask = N'($urandom_range(1, 255));
         wr(ADDR_MASK, DW'(m_mask));
         while ((m_pend & m_mask) != 0) begin
            e = lowest(m_pend & m_mask);
            wait_int("rnd_int");
            ack();
            chk("rnd_vec", DW'(bus.int_vector), DW'(e));
            m_pend[e] = 0;
            rd(ADDR_STATUS, DW'({1'b1, VW'(e)}), "rnd_status");
            rd(ADDR_PEND, DW'(m_pend), "rnd_pend_after");
            wr(ADDR_EOI, 0);
         end
         tick(3);
         chk("rnd_quiet", DW'(bus.interrupt), 0);
      end
      tick(2);
      chk("rd_q_empty", DW'(rd_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
